irq_pending_arbiter: RTL and testbench
======================================

// Module: irq_pending_arbiter
// PURPOSE
//  Upstream stage of the priority encoder path: captures rising edges on N
//  interrupt request lines into sticky pending bits and applies a mask.
//  Offers the highest-index enabled pending source as a binary ID over a
//  valid/ready handshake. Clears that pending bit on acceptance. Reports
//  lost (re-asserted while pending) requests.
// PARAMETERS
//  N_SRC  8                   number of request lines (>=2)
//  ID_W   $clog2(N_SRC)       width of irq_id
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  irq_in     in   N_SRC   level request lines; a 0->1 transition = one event
//  irq_mask   in   N_SRC   1 = source disabled for selection (still latched)
//  irq_valid  out  1       offer valid
//  irq_id     out  ID_W    offered source index; stable while irq_valid=1
//  irq_ready  in   1       consumer accepts when irq_valid & irq_ready
//  irq_none   out  1       1 = no enabled pending source and no offer
//  lost       out  N_SRC   sticky: an edge arrived while that bit was pending
//  lost_clr   in   N_SRC   1 = clear corresponding lost bit (W1C)
// BEHAVIOUR
//  Reset (async, rst_n=0): irq_q=0, pending=0, lost=0, state=IDLE,
//    irq_valid=0, irq_id=0, irq_none=1. Outputs drop immediately, even mid-offer.
//  Edge detect: edge = irq_in & ~irq_q; irq_q <= irq_in every cycle.
//  pending[i] set on edge[i]. Cleared only by an accepted handshake for id i.
//    Set and clear of the same bit in one cycle: set wins (bit stays 1).
//  lost[i] <= 1 when edge[i] & pending[i] & ~(clear of i this cycle).
//    Set beats lost_clr in the same cycle.
//  Selection: sel = pending & ~irq_mask. Highest set index wins (MSB priority).
//  FSM, 2 states, registered outputs:
//    IDLE : irq_valid=0. If |sel: irq_id<=encode(sel), irq_valid<=1, ->OFFER.
//    OFFER: irq_valid=1 and irq_id held; no preemption by higher arrivals.
//           Masking the offered source does not withdraw the offer.
//           On irq_ready: pending[irq_id] cleared, irq_valid<=0, ->IDLE.
//  Handshakes are at most one per 2 cycles (IDLE re-evaluates after each accept).
//  Latency: irq_in rises before edge k -> pending set at k -> irq_valid=1 after k+1.
//  irq_none (registered) = (state==IDLE) & ~|sel_next; 0 while OFFER.
//  irq_ready while irq_valid=0: ignored.
// CONFIGURATION
//  IRQ_SYNC_EN defined: irq_in passes through a 2-flop synchroniser (reset 0)
//    before edge detect. Event-to-valid latency becomes 4 cycles.
//  IRQ_SYNC_EN undefined: irq_in is used directly; the source must be synchronous to clk.
// STRUCTURE
//  Package irq_pkg: typedef enum logic {IDLE, OFFER} irq_state_t;
//    localparam N_SRC_DEF = 8.
//  Sub-module prio_enc_n #(N): combinational; in[N-1:0] -> idx (MSB set), none.
//    Instantiated once on sel.
// TESTING (N_SRC=8, IRQ_SYNC_EN undefined)
//  1 rst_n=0 mid-run -> irq_valid=0, irq_id=0, irq_none=1, lost=0 without clk edge.
//  2 irq_in 00->20, ready=1 -> irq_valid=1 two cycles later, irq_id=5, irq_none=0;
//    after accept irq_none=1.
//  3 irq_in 00->81, ready=0 for 3 cycles -> irq_id=7 held; accept; next offer irq_id=0.
//  4 irq_mask=80, irq_in 00->81 -> irq_id=0 offered and accepted;
//    irq_mask=00 -> irq_id=7 offered.
//  5 bit 3 pending, irq_in[3] pulsed again -> lost=08; lost_clr=08 -> lost=00;
//    pending[3] cleared by one accept.
//  6 accept of id 2 in the same cycle as a new edge on bit 2 -> pending[2] stays 1,
//    irq_id=2 offered again.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and defaults for the interrupt pending arbiter
package irq_pkg;

  typedef enum logic {IDLE, OFFER} irq_state_t;

  localparam int N_SRC_DEF = 8;

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// rtl/irq_pending_arbiter_if.sv - request/mask/offer/lost signal bundle of the arbiter
interface irq_pending_arbiter_if
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC)
);

  logic [N_SRC-1:0] irq_in;
  logic [N_SRC-1:0] irq_mask;
  logic             irq_valid;
  logic [ID_W-1:0]  irq_id;
  logic             irq_ready;
  logic             irq_none;
  logic [N_SRC-1:0] lost;
  logic [N_SRC-1:0] lost_clr;

  modport master (
    input  irq_in, irq_mask, irq_ready, lost_clr,
    output irq_valid, irq_id, irq_none, lost
  );

  modport slave (
    output irq_in, irq_mask, irq_ready, lost_clr,
    input  irq_valid, irq_id, irq_none, lost
  );

endinterface

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - combinational priority encoder, highest set index wins
module prio_enc_n #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  always_comb begin
    idx  = '0;
    none = ~|in_vec;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - edge-latched pending bits, masked MSB-priority offer, lost tracking
// Optional input synchroniser enabled by defining IRQ_SYNC_EN.
module irq_pending_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irq_pending_arbiter_if.master bus
);

  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] lost_q, lost_d;
  logic [N_SRC-1:0] edge_vec, clr_vec, sel, sel_next;
  logic [ID_W-1:0]  sel_idx;
  logic             sel_none;
  logic             accept;

  irq_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             none_q, none_d;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq_in;
`endif

  assign accept = valid_q & bus.irq_ready;
  assign sel    = pending_q & ~bus.irq_mask;

  prio_enc_n #(.N(N_SRC), .IDX_W(ID_W)) u_prio (
    .in_vec (sel),
    .idx    (sel_idx),
    .none   (sel_none)
  );

  // A new edge on the bit being accepted keeps it pending and is not a loss.
  always_comb begin
    edge_vec = irq_s & ~irq_q;
    clr_vec  = '0;
    if (accept) clr_vec[id_q] = 1'b1;
    pending_d = (pending_q & ~clr_vec) | edge_vec;
    lost_d    = (lost_q & ~bus.lost_clr) | (edge_vec & pending_q & ~clr_vec);
    sel_next  = pending_d & ~bus.irq_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      lost_q    <= '0;
    end else begin
      irq_q     <= irq_s;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  // The offer is held until accepted; no preemption or withdrawal by masking.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (!sel_none) begin
          id_d    = sel_idx;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (bus.irq_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    none_d = (state_d == IDLE) & ~|sel_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      none_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      none_q  <= none_d;
    end
  end

  assign bus.irq_valid = valid_q;
  assign bus.irq_id    = id_q;
  assign bus.irq_none  = none_q;
  assign bus.lost      = lost_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - directed self-checking bench for irq_pending_arbiter
module tb_irq_pending_arbiter;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  irq_pending_arbiter_if #(.N_SRC(8)) bus ();

  irq_pending_arbiter #(.N_SRC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.irq_in    = 8'h00;
    bus.irq_mask  = 8'h00;
    bus.irq_ready = 1'b0;
    bus.lost_clr  = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %0b want 0", bus.irq_valid);
    end
    tests_run++;
    if (bus.irq_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_id: got %0d want 0", bus.irq_id);
    end
    tests_run++;
    if (bus.irq_none !== 1'b1 || bus.lost !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_none_lost: got none=%0b lost=%02h want none=1 lost=00", bus.irq_none, bus.lost);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.irq_ready = 1'b1;
    bus.irq_in    = 8'h20;
    tick();
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd5) begin
      tests_failed++;
      $display("FAIL single_offer: got valid=%0b id=%0d want valid=1 id=5", bus.irq_valid, bus.irq_id);
    end
    tests_run++;
    if (bus.irq_none !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_none_busy: got %0b want 0", bus.irq_none);
    end
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_after_accept: got valid=%0b none=%0b want valid=0 none=1", bus.irq_valid, bus.irq_none);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold_priority();
    bus.irq_in = 8'h81;
    tick();
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin
      tests_failed++;
      $display("FAIL prio_first: got valid=%0b id=%0d want valid=1 id=7", bus.irq_valid, bus.irq_id);
    end
    tick();
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin
      tests_failed++;
      $display("FAIL prio_hold: got valid=%0b id=%0d want valid=1 id=7", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_accept_gap: got valid=%0b want 0", bus.irq_valid);
    end
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL prio_second: got valid=%0b id=%0d want valid=1 id=0", bus.irq_valid, bus.irq_id);
    end
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b1) begin
      tests_failed++;
      $display("FAIL prio_drained: got valid=%0b none=%0b want valid=0 none=1", bus.irq_valid, bus.irq_none);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_mask();
    bus.irq_mask  = 8'h80;
    bus.irq_in    = 8'h81;
    bus.irq_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL mask_low_offer: got valid=%0b id=%0d want valid=1 id=0", bus.irq_valid, bus.irq_id);
    end
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_hidden: got valid=%0b none=%0b want valid=0 none=1", bus.irq_valid, bus.irq_none);
    end
    bus.irq_mask = 8'h00;
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin
      tests_failed++;
      $display("FAIL mask_unmasked: got valid=%0b id=%0d want valid=1 id=7", bus.irq_valid, bus.irq_id);
    end
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_drained: got valid=%0b none=%0b want valid=0 none=1", bus.irq_valid, bus.irq_none);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lost();
    bus.irq_in = 8'h08;
    tick();
    bus.irq_in = 8'h00;
    tick();
    bus.irq_in = 8'h08;
    tick();
    tests_run++;
    if (bus.lost !== 8'h08) begin
      tests_failed++;
      $display("FAIL lost_set: got %02h want 08", bus.lost);
    end
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin
      tests_failed++;
      $display("FAIL lost_offer: got valid=%0b id=%0d want valid=1 id=3", bus.irq_valid, bus.irq_id);
    end
    bus.irq_in   = 8'h00;
    bus.lost_clr = 8'h08;
    tick();
    bus.lost_clr = 8'h00;
    tests_run++;
    if (bus.lost !== 8'h00) begin
      tests_failed++;
      $display("FAIL lost_clear: got %02h want 00", bus.lost);
    end
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b1) begin
      tests_failed++;
      $display("FAIL lost_single_accept: got valid=%0b none=%0b want valid=0 none=1", bus.irq_valid, bus.irq_none);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_set_wins();
    bus.irq_in = 8'h04;
    tick();
    bus.irq_in = 8'h00;
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd2) begin
      tests_failed++;
      $display("FAIL setwin_offer: got valid=%0b id=%0d want valid=1 id=2", bus.irq_valid, bus.irq_id);
    end
    bus.irq_in    = 8'h04;
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b0 || bus.lost !== 8'h00) begin
      tests_failed++;
      $display("FAIL setwin_kept: got valid=%0b none=%0b lost=%02h want valid=0 none=0 lost=00", bus.irq_valid, bus.irq_none, bus.lost);
    end
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd2) begin
      tests_failed++;
      $display("FAIL setwin_reoffer: got valid=%0b id=%0d want valid=1 id=2", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b1) begin
      tests_failed++;
      $display("FAIL setwin_drained: got valid=%0b none=%0b want valid=0 none=1", bus.irq_valid, bus.irq_none);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    bus.irq_in = 8'h01;
    tick();
    bus.irq_in = 8'h00;
    tick();
    bus.irq_in = 8'h01;
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b1 || bus.lost !== 8'h01) begin
      tests_failed++;
      $display("FAIL areset_pre: got valid=%0b lost=%02h want valid=1 lost=01", bus.irq_valid, bus.lost);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_id !== 3'd0) begin
      tests_failed++;
      $display("FAIL areset_offer: got valid=%0b id=%0d want valid=0 id=0", bus.irq_valid, bus.irq_id);
    end
    tests_run++;
    if (bus.irq_none !== 1'b1 || bus.lost !== 8'h00) begin
      tests_failed++;
      $display("FAIL areset_none_lost: got none=%0b lost=%02h want none=1 lost=00", bus.irq_none, bus.lost);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus.irq_valid !== 1'b0 || bus.irq_none !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_after: got valid=%0b none=%0b want valid=0 none=1", bus.irq_valid, bus.irq_none);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_hold_priority();
    test_mask();
    test_lost();
    test_set_wins();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
